// File: rtl/uart_arb_defs.sv
// Shared constants for the UART transmit arbiter: FSM state codes,
// default sizing and a width helper usable in parameter expressions.
package uart_arb_defs;

  localparam logic [1:0] ST_ARB       = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  localparam int DEFAULT_NREQ      = 4;
  localparam int DEFAULT_MAX_BURST = 16;

  // Bits needed to hold values 0..value-1 (minimum 1).
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request bit at or after
// ptr (wrapping) is returned one-hot, together with an any-request flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          any_valid
);

  logic [2*N-1:0] rot_wide;
  logic [N-1:0]   rot;
  logic [N-1:0]   rot_oh;
  logic [2*N-1:0] back_wide;

  // Rotate so ptr sits at bit 0, isolate the lowest set bit, rotate back.
  assign rot_wide  = {req, req} >> ptr;
  assign rot       = rot_wide[N-1:0];
  assign rot_oh    = rot & (~rot + N'(1));
  assign back_wide = {rot_oh, rot_oh} << ptr;
  assign gnt       = back_wide[2*N-1:N];
  assign any_valid = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the single UART transmitter; a winner keeps the UART
// until its last byte, MAX_BURST bytes, or its valid drops.
module uart_tx_arbiter
  import uart_arb_defs::*;
#(
  parameter int NREQ      = DEFAULT_NREQ,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   grant,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_busy
);

  localparam int PTR_W = clog2(NREQ);
  localparam int BC_W  = clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0]  BURST_LIMIT = BC_W'(MAX_BURST);
  localparam logic [PTR_W-1:0] LAST_IDX    = PTR_W'(NREQ - 1);

  logic [1:0]       state_reg;
  logic [NREQ-1:0]  grant_reg;
  logic [PTR_W-1:0] rr_ptr_reg;
  logic [BC_W-1:0]  burst_cnt_reg;
  logic             last_q_reg;
  logic [7:0]       tx_data_reg;
  logic             tx_wr_reg;

  logic [NREQ-1:0]  pick_gnt;
  logic             any_valid;
  logic             granted_valid;
  logic             granted_last;
  logic [7:0]       granted_data;
  logic [PTR_W-1:0] grant_idx;
  logic [PTR_W-1:0] rr_ptr_next;
  logic [7:0]       lane_data [NREQ];

  rr_pick #(
    .N  (NREQ),
    .PW (PTR_W)
  ) u_rr_pick (
    .req       (req_valid),
    .ptr       (rr_ptr_reg),
    .gnt       (pick_gnt),
    .any_valid (any_valid)
  );

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign lane_data[gi] = grant_reg[gi] ? req_data[8*gi +: 8] : 8'h00;
    end
  endgenerate

  always_comb begin
    granted_data = 8'h00;
    grant_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      granted_data = granted_data | lane_data[i];
      if (grant_reg[i]) grant_idx = PTR_W'(i);
    end
  end

  assign granted_valid = |(req_valid & grant_reg);
  assign granted_last  = |(req_last & grant_reg);
  assign rr_ptr_next   = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);

  assign req_ready = (state_reg == ST_SEND) ? grant_reg : '0;
  assign grant     = grant_reg;
  assign tx_data   = tx_data_reg;
  assign tx_wr     = tx_wr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_ARB;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
      last_q_reg    <= 1'b0;
      tx_data_reg   <= 8'h00;
      tx_wr_reg     <= 1'b0;
    end else begin
      tx_wr_reg <= 1'b0;
      case (state_reg)
        ST_ARB: begin
          // A UART still busy (e.g. after a reset mid-byte) blocks any new grant.
          if (any_valid && !tx_busy) begin
            grant_reg     <= pick_gnt;
            burst_cnt_reg <= '0;
            state_reg     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (granted_valid) begin
            tx_data_reg   <= granted_data;
            last_q_reg    <= granted_last;
            burst_cnt_reg <= burst_cnt_reg + BC_W'(1);
            tx_wr_reg     <= 1'b1;
            state_reg     <= ST_WAIT_ACK;
          end else begin
            grant_reg  <= '0;
            rr_ptr_reg <= rr_ptr_next;
            state_reg  <= ST_ARB;
          end
        end
        ST_WAIT_ACK: begin
          // tx_busy only rises one cycle after the strobe, so it is not looked at here.
          state_reg <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (last_q_reg || burst_cnt_reg == BURST_LIMIT || !granted_valid) begin
              grant_reg  <= '0;
              rr_ptr_reg <= rr_ptr_next;
              state_reg  <= ST_ARB;
            end else begin
              state_reg <= ST_SEND;
            end
          end
        end
        default: state_reg <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: a UART busy model, per-requester byte
// queues and a message-level round-robin model predicting the transmitted stream.
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 16;
  localparam int BUSY_CYC  = 20;   // 10 bit-times of 2 clocks each
  localparam int QDEPTH    = 256;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_busy;

  uart_tx_arbiter #(
    .NREQ      (NREQ),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant     (grant),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  // UART core: busy from the cycle after tx_wr, unaffected by the arbiter reset.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_wr === 1'b1) busy_cnt <= BUSY_CYC;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  logic [8:0] src_mem [NREQ][QDEPTH];
  int head [NREQ];
  int tail [NREQ];
  int exp_q[$];
  int obs_q[$];
  int model_ptr;
  int n_vec = 0;
  int n_err = 0;
  logic [NREQ-1:0] acc = '0;
  logic [NREQ-1:0] prev_acc = '0;
  logic prev_busy = 1'b0;
  logic pend_rel = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int oh_idx(input logic [NREQ-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic bit queues_empty();
    bit e;
    e = 1'b1;
    for (int r = 0; r < NREQ; r++) if (head[r] != tail[r]) e = 1'b0;
    return e;
  endfunction

  task automatic clear_q();
    for (int r = 0; r < NREQ; r++) begin
      head[r] = 0;
      tail[r] = 0;
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] b, input bit last);
    src_mem[r][tail[r]] = {last, b};
    tail[r]++;
  endtask

  // Message-level reference: serve the first non-empty queue from the pointer,
  // for up to MAX_BURST bytes, stopping early at a last flag or an empty queue.
  task automatic model_append();
    int h [NREQ];
    int r, n;
    bit found, stop;
    logic [8:0] e;
    for (int i = 0; i < NREQ; i++) h[i] = head[i];
    forever begin
      found = 1'b0;
      r = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!found && h[(model_ptr + k) % NREQ] != tail[(model_ptr + k) % NREQ]) begin
          found = 1'b1;
          r = (model_ptr + k) % NREQ;
        end
      end
      if (!found) break;
      n = 0;
      stop = 1'b0;
      while (!stop) begin
        e = src_mem[r][h[r]];
        h[r]++;
        n++;
        exp_q.push_back(r * 256 + int'(e[7:0]));
        stop = e[8] || (n == MAX_BURST) || (h[r] == tail[r]);
      end
      model_ptr = (r + 1) % NREQ;
    end
  endtask

  task automatic drive_inputs();
    for (int r = 0; r < NREQ; r++) begin
      if (head[r] != tail[r]) begin
        req_valid[r]        = 1'b1;
        req_data[8*r +: 8]  = src_mem[r][head[r]][7:0];
        req_last[r]         = src_mem[r][head[r]][8];
      end else begin
        req_valid[r]        = 1'b0;
        req_data[8*r +: 8]  = 8'($urandom);
        req_last[r]         = 1'($urandom);
      end
    end
  endtask

  task automatic monitor();
    check_eq("wr_while_busy", 32'(tx_wr & tx_busy), 32'd0);
    check_eq("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    check_eq("ready_outside_grant", 32'(req_ready & ~grant), 32'd0);
    check_eq("wr_per_accept", 32'(tx_wr), 32'(prev_acc != '0));
    if (pend_rel) check_eq("release_on_drop", 32'(grant), 32'd0);
    pend_rel = prev_busy && !tx_busy && (grant != '0) && ((grant & req_valid) == '0);
    if (tx_wr) begin
      obs_q.push_back(oh_idx(grant) * 256 + int'(tx_data));
      $display("tx byte %02h from req %0d (grant %b)", tx_data, oh_idx(grant), grant);
    end
    acc       = rst ? '0 : (req_valid & req_ready);
    prev_acc  = acc;
    prev_busy = tx_busy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int r = 0; r < NREQ; r++) if (acc[r]) head[r]++;
    drive_inputs();
    @(negedge clk);
    monitor();
  endtask

  task automatic compare_streams(input string name);
    int n;
    check_eq({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check_eq({name, "_byte"}, 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_until_idle(input string name);
    bit done;
    done = 1'b0;
    for (int cyc = 0; cyc < 8000 && !done; cyc++) begin
      tick();
      done = queues_empty() && (obs_q.size() >= exp_q.size()) && !tx_busy && (grant == '0);
    end
    check_eq({name, "_finished"}, 32'(done), 32'd1);
    compare_streams(name);
  endtask

  task automatic push_msg(input int r, input int len, input bit with_last);
    for (int i = 0; i < len; i++) push_byte(r, 8'($urandom), with_last && (i == len - 1));
  endtask

  initial begin
    bit hit;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    clear_q();
    model_ptr = 0;
    repeat (3) tick();
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_tx_wr", 32'(tx_wr), 32'd0);
    check_eq("rst_tx_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Req0 sends "HI\n", checking grant/write latency on the way.
    clear_q();
    push_byte(0, 8'h48, 1'b0);
    push_byte(0, 8'h49, 1'b0);
    push_byte(0, 8'h0a, 1'b1);
    model_append();
    tick();
    check_eq("lat_grant_c0", 32'(grant), 32'd0);
    tick();
    check_eq("lat_grant_c1", 32'(grant), 32'b0001);
    check_eq("lat_ready_c1", 32'(req_ready), 32'b0001);
    check_eq("lat_wr_c1", 32'(tx_wr), 32'd0);
    tick();
    check_eq("lat_wr_c2", 32'(tx_wr), 32'd1);
    check_eq("lat_data_c2", 32'(tx_data), 32'h48);
    run_until_idle("hi");

    // Pointer back to 0, then all four one-byte messages at once.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_ptr = 0;
    clear_q();
    push_byte(0, 8'h41, 1'b1);
    push_byte(1, 8'h42, 1'b1);
    push_byte(2, 8'h43, 1'b1);
    push_byte(3, 8'h44, 1'b1);
    model_append();
    check_eq("abcd_model_order", 32'(exp_q[3]), 32'(3 * 256 + 8'h44));
    run_until_idle("abcd");

    // Req1 alone moves the pointer to 2; then req2 streams 40 bytes beside req1.
    clear_q();
    push_msg(1, 1, 1'b1);
    model_append();
    run_until_idle("ptr_to_2");
    clear_q();
    push_msg(2, 40, 1'b0);
    push_msg(1, 3, 1'b1);
    model_append();
    run_until_idle("burst");

    // Reset while the UART is mid-byte.
    clear_q();
    push_msg(0, 6, 1'b1);
    push_msg(3, 2, 1'b1);
    model_append();
    hit = 1'b0;
    for (int c = 0; c < 50 && !hit; c++) begin
      tick();
      hit = (obs_q.size() >= 1);
    end
    check_eq("first_byte_before_rst", 32'(hit), 32'd1);
    repeat (3) tick();
    check_eq("busy_before_rst", 32'(tx_busy), 32'd1);
    rst = 1'b1;
    tick();
    check_eq("midrst_grant", 32'(grant), 32'd0);
    check_eq("midrst_tx_wr", 32'(tx_wr), 32'd0);
    check_eq("midrst_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("no_grant_while_busy", 32'(grant), 32'd0);
    while (exp_q.size() > obs_q.size()) void'(exp_q.pop_back());
    model_ptr = 0;
    model_append();
    run_until_idle("midrst");

    // Req1 drops valid without a last byte; others must still be served.
    clear_q();
    push_msg(1, 3, 1'b0);
    push_msg(2, 2, 1'b1);
    push_msg(0, 4, 1'b1);
    model_append();
    run_until_idle("drop");

    // Randomised traffic.
    for (int p = 0; p < 6; p++) begin
      clear_q();
      for (int r = 0; r < NREQ; r++) begin
        if ($urandom_range(0, 1) == 1) begin
          int nmsg;
          nmsg = $urandom_range(1, 3);
          for (int m = 0; m < nmsg; m++) begin
            push_msg(r, $urandom_range(1, 20), !((m == nmsg - 1) && ($urandom_range(0, 3) == 0)));
          end
        end
      end
      model_append();
      run_until_idle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
